// File: rtl/rhythm_pkg.sv
// Shared rhythm-game constants and helpers: judgement points, combo width, multiplier width
// and the tier lookup used to turn a combo length into a score multiplier.
package rhythm_pkg;
  localparam int PTS_GOOD_DEF    = 100;
  localparam int PTS_PERFECT_DEF = 300;
  localparam int COMBO_W_DEF     = 10;
  localparam int MULT_W          = 4;

  typedef logic [COMBO_W_DEF-1:0] combo_t;

  // Tier multiplier by comparison against k*tier_step; tier_step is a constant so no divider appears.
  function automatic logic [MULT_W-1:0] tier_mult(input int unsigned combo,
                                                  input int unsigned tier_step,
                                                  input int unsigned mult_max);
    logic [MULT_W-1:0] m;
    m = MULT_W'(1);
    for (int unsigned k = 1; k < 8; k++) begin
      if (k < mult_max && combo >= k * tier_step) m = m + MULT_W'(1);
    end
    return m;
  endfunction
endpackage

// File: rtl/judge_sum.sv
// Combinational judgement reducer: valid hit count, point sum and any-miss over all lanes.
// A lane with both hit and miss counts as a miss only.
module judge_sum
  import rhythm_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PTS_GOOD    = PTS_GOOD_DEF,
  parameter int PTS_PERFECT = PTS_PERFECT_DEF,
  parameter int NH_W        = $clog2(LANES + 1),
  parameter int PTS_W       = 16
) (
  input  logic [LANES-1:0] hit,
  input  logic [LANES-1:0] perfect,
  input  logic [LANES-1:0] miss,
  output logic [NH_W-1:0]  nh,
  output logic [PTS_W-1:0] pts,
  output logic             any_miss
);

  always_comb begin
    nh       = '0;
    pts      = '0;
    any_miss = |miss;
    for (int i = 0; i < LANES; i++) begin
      if (hit[i] && !miss[i]) begin
        nh  = nh + NH_W'(1);
        pts = pts + (perfect[i] ? PTS_W'(PTS_PERFECT) : PTS_W'(PTS_GOOD));
      end
    end
  end

endmodule

// File: rtl/combo_score_tracker.sv
// Combo, best-combo, tiered multiplier, saturating score and full-combo tracker.
// Inputs are single-cycle pulses sampled every clock (no valid/ready); all outputs are registered.
module combo_score_tracker
  import rhythm_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int COMBO_W     = COMBO_W_DEF,
  parameter int COMBO_MAX   = 999,
  parameter int SCORE_W     = 24,
  parameter int PTS_GOOD    = PTS_GOOD_DEF,
  parameter int PTS_PERFECT = PTS_PERFECT_DEF,
  parameter int TIER_STEP   = 10,
  parameter int MULT_MAX    = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Clear,
  input  logic [LANES-1:0]   i_Hit,
  input  logic [LANES-1:0]   i_Perfect,
  input  logic [LANES-1:0]   i_Miss,
  output logic [COMBO_W-1:0] o_Combo,
  output logic [COMBO_W-1:0] o_MaxCombo,
  output logic [MULT_W-1:0]  o_Mult,
  output logic [SCORE_W-1:0] o_Score,
  output logic               o_Milestone,
  output logic               o_FullCombo
);

  localparam int NH_W = $clog2(LANES + 1);
  localparam logic [COMBO_W:0] CMAX = (COMBO_W + 1)'(COMBO_MAX);

  logic [NH_W-1:0]    nh;
  logic [SCORE_W-1:0] pts;
  logic               any_miss;

  judge_sum #(
    .LANES      (LANES),
    .PTS_GOOD   (PTS_GOOD),
    .PTS_PERFECT(PTS_PERFECT),
    .NH_W       (NH_W),
    .PTS_W      (SCORE_W)
  ) u_judge_sum (
    .hit     (i_Hit),
    .perfect (i_Perfect),
    .miss    (i_Miss),
    .nh      (nh),
    .pts     (pts),
    .any_miss(any_miss)
  );

  logic [COMBO_W-1:0] combo_q, max_q, combo_d, max_d;
  logic [MULT_W-1:0]  mult_q, mult_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               milestone_q, milestone_d;
  logic               fc_q, fc_d;
  logic               missed_q, missed_d;
  logic [COMBO_W:0]   combo_sum;
  logic [SCORE_W+3:0] score_sum;

  always_comb begin
    // Score uses the multiplier registered before this cycle; hits in a miss cycle still count.
    score_sum = {4'b0, score_q} + ({4'b0, pts} * {{SCORE_W{1'b0}}, mult_q});
    score_d   = (|score_sum[SCORE_W+3:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];

    combo_sum = {1'b0, combo_q} + (COMBO_W + 1)'(nh);
    if (any_miss)               combo_d = '0;
    else if (combo_sum > CMAX)  combo_d = CMAX[COMBO_W-1:0];
    else                        combo_d = combo_sum[COMBO_W-1:0];

    mult_d      = tier_mult(32'(combo_d), TIER_STEP, MULT_MAX);
    milestone_d = (mult_d > mult_q);
    max_d       = (combo_d > max_q) ? combo_d : max_q;

    // Once any miss is seen the full-combo flag cannot come back until a clear.
    missed_d = missed_q | any_miss;
    fc_d     = !missed_d && (fc_q || (nh != '0));
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      combo_q     <= '0;
      max_q       <= '0;
      mult_q      <= MULT_W'(1);
      score_q     <= '0;
      milestone_q <= 1'b0;
      fc_q        <= 1'b0;
      missed_q    <= 1'b0;
    end else if (i_Clear) begin
      combo_q     <= '0;
      max_q       <= '0;
      mult_q      <= MULT_W'(1);
      score_q     <= '0;
      milestone_q <= 1'b0;
      fc_q        <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      combo_q     <= combo_d;
      max_q       <= max_d;
      mult_q      <= mult_d;
      score_q     <= score_d;
      milestone_q <= milestone_d;
      fc_q        <= fc_d;
      missed_q    <= missed_d;
    end
  end

  assign o_Combo     = combo_q;
  assign o_MaxCombo  = max_q;
  assign o_Mult      = mult_q;
  assign o_Score     = score_q;
  assign o_Milestone = milestone_q;
  assign o_FullCombo = fc_q;

endmodule

// File: tb/tb_combo_score_tracker.sv
// Scoreboard bench for combo_score_tracker: a driver pushes expected outputs from a
// behavioural model, a monitor pops and compares one cycle later.
module tb_combo_score_tracker;
  localparam int OUT_W = 50;
  localparam longint SMAX = (64'd1 << 24) - 1;

  logic        clk, rst, clear;
  logic [3:0]  hit, perf, miss;
  logic [9:0]  combo, maxc;
  logic [3:0]  mult;
  logic [23:0] score;
  logic        milestone, fullc;

  combo_score_tracker dut (
    .i_Clk(clk), .i_Rst(rst), .i_Clear(clear),
    .i_Hit(hit), .i_Perfect(perf), .i_Miss(miss),
    .o_Combo(combo), .o_MaxCombo(maxc), .o_Mult(mult), .o_Score(score),
    .o_Milestone(milestone), .o_FullCombo(fullc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [OUT_W-1:0] exp_q[$];

  // behavioural reference model
  int     m_combo, m_max, m_mult, m_ms, m_fc, m_spoiled;
  longint m_score;

  task automatic model_reset();
    m_combo = 0; m_max = 0; m_mult = 1; m_score = 0;
    m_ms = 0; m_fc = 0; m_spoiled = 0;
  endtask

  task automatic model_step(input logic [3:0] h, input logic [3:0] p,
                            input logic [3:0] m, input logic clr);
    int nh, pts, new_mult;
    if (clr) begin
      model_reset();
    end else begin
      nh = 0; pts = 0;
      for (int i = 0; i < 4; i++)
        if (h[i] && !m[i]) begin
          nh++;
          pts += p[i] ? 300 : 100;
        end
      m_score = m_score + longint'(pts) * m_mult;
      if (m_score > SMAX) m_score = SMAX;
      if (m != 0) m_combo = 0;
      else m_combo = (m_combo + nh > 999) ? 999 : m_combo + nh;
      new_mult = m_combo / 10 + 1;
      if (new_mult > 4) new_mult = 4;
      m_ms = (new_mult > m_mult) ? 1 : 0;
      m_mult = new_mult;
      if (m_combo > m_max) m_max = m_combo;
      if (m != 0) m_spoiled = 1;
      if (!m_spoiled && nh > 0) m_fc = 1;
      if (m_spoiled != 0) m_fc = 0;
    end
  endtask

  function automatic logic [OUT_W-1:0] pack_exp();
    return {10'(m_combo), 10'(m_max), 4'(m_mult), 24'(m_score), 1'(m_ms), 1'(m_fc)};
  endfunction

  // driver
  task automatic drive(input logic [3:0] h, input logic [3:0] p,
                       input logic [3:0] m, input logic clr);
    @(negedge clk);
    hit = h; perf = p; miss = m; clear = clr;
    model_step(h, p, m, clr);
    exp_q.push_back(pack_exp());
  endtask

  task automatic hit_to(input int target);
    int n;
    for (int guard = 0; guard < 400 && m_combo < target; guard++) begin
      n = target - m_combo;
      if (n > 4) n = 4;
      drive(4'((1 << n) - 1), 4'h0, 4'h0, 1'b0);
    end
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // monitor: every clock presents a new output word
  always @(posedge clk) begin
    logic [OUT_W-1:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {combo, maxc, mult, score, milestone, fullc};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL out @%0t: got combo=%0d max=%0d mult=%0d score=%0d ms=%0d fc=%0d expected combo=%0d max=%0d mult=%0d score=%0d ms=%0d fc=%0d",
                 $time, a[49:40], a[39:30], a[29:26], a[25:2], a[1], a[0],
                 e[49:40], e[39:30], e[29:26], e[25:2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; hit = '0; perf = '0; miss = '0;
    model_reset();
    #12;
    chk("rst_combo", combo, 0);
    chk("rst_max", maxc, 0);
    chk("rst_mult", mult, 1);
    chk("rst_score", score, 0);
    chk("rst_ms", milestone, 0);
    chk("rst_fc", fullc, 0);
    @(negedge clk);
    rst = 1'b0;

    // three single good hits on separate cycles
    repeat (3) drive(4'h1, 4'h0, 4'h0, 1'b0);
    // reach combo 9, tier crossing, then a perfect hit at x2
    hit_to(9);
    drive(4'h2, 4'h0, 4'h0, 1'b0);
    drive(4'h1, 4'h1, 4'h0, 1'b0);
    drive(4'h0, 4'h0, 4'h0, 1'b0);
    // combo 25, then two perfect hits plus a miss on another lane
    hit_to(25);
    drive(4'h3, 4'h3, 4'h4, 1'b0);
    // same-lane hit and miss
    hit_to(3);
    drive(4'h1, 4'h1, 4'h1, 1'b0);
    // combo saturation
    hit_to(998);
    drive(4'hF, 4'h0, 4'h0, 1'b0);
    drive(4'hF, 4'hF, 4'h0, 1'b0);
    // score saturation
    for (int g = 0; g < 5000 && m_score < SMAX; g++) drive(4'hF, 4'hF, 4'h0, 1'b0);
    repeat (3) drive(4'hF, 4'hF, 4'h0, 1'b0);
    // clear together with hits
    drive(4'hF, 4'hA, 4'h0, 1'b1);
    drive(4'h0, 4'h0, 4'h0, 1'b0);

    // randomized play
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] h, p, m;
      logic       cl;
      h  = 4'($urandom_range(0, 15));
      p  = 4'($urandom_range(0, 15));
      m  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      cl = ($urandom_range(0, 299) == 0);
      drive(h, p, m, cl);
    end

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_combo", combo, 0);
    chk("arst_max", maxc, 0);
    chk("arst_mult", mult, 1);
    chk("arst_score", score, 0);
    chk("arst_ms", milestone, 0);
    chk("arst_fc", fullc, 0);
    @(posedge clk);
    #4;
    rst = 1'b0;
    for (int c = 0; c < 50; c++)
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'h0, 1'b0);
    drive(4'h0, 4'h0, 4'h0, 1'b0);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/combo_score_tracker.md
# combo_score_tracker

Multi-lane combo, multiplier and score tracker for the rhythm game core. It takes per-lane judgement pulses from the note judges and keeps a saturating combo, a best-combo record and a tiered score multiplier. It also keeps a saturating score accumulator and a full-combo flag. Its outputs feed the score/combo display and the end-of-song result screen.

## Interface
- LANES, 4, number of note lanes (1..8)
- COMBO_W, 10, combo counter width
- COMBO_MAX, 999, combo saturation value (< 2^COMBO_W)
- SCORE_W, 24, score accumulator width
- PTS_GOOD, 100, base points for a good hit
- PTS_PERFECT, 300, base points for a perfect hit
- TIER_STEP, 10, combo length per multiplier tier (≥ 1)
- MULT_MAX, 4, multiplier ceiling (1..8)

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous, active-high reset
- i_Clear  in  1  synchronous song-start clear, single cycle
- i_Hit  in  LANES  per-lane hit pulse, 1 clk
- i_Perfect  in  LANES  per-lane grade; qualifies i_Hit (1 = perfect, 0 = good)
- i_Miss  in  LANES  per-lane miss pulse, 1 clk
- o_Combo  out  COMBO_W  current combo
- o_MaxCombo  out  COMBO_W  best combo since clear
- o_Mult  out  4  current multiplier, 1..MULT_MAX
- o_Score  out  SCORE_W  accumulated score
- o_Milestone  out  1  one-clk pulse when the combo enters a new tier
- o_FullCombo  out  1  at least one hit and no miss since clear

## Operation
- Reset (async) and i_Clear (sync) drive the same values:
  - o_Combo = 0, o_MaxCombo = 0, o_Score = 0
  - o_Mult = 1, o_Milestone = 0, o_FullCombo = 0
- i_Clear has priority over all judgement inputs in its cycle; those inputs are discarded.
- Per-lane conflict: if i_Hit[n] and i_Miss[n] are both high, the lane counts as a miss only.
- Per cycle:
  - nh = popcount of valid hits; anyMiss = OR of i_Miss.
  - pts = Σ over valid hits of (i_Perfect[n] ? PTS_PERFECT : PTS_GOOD).
- Score update:
  - Score += pts × o_Mult, using the registered multiplier from before this cycle.
  - Hits in a miss cycle still score.
  - Computed at SCORE_W+4 bits, then saturated at 2^SCORE_W−1; the score never wraps.
- Combo update:
  - anyMiss: combo = 0.
  - Otherwise: combo = min(combo + nh, COMBO_MAX); it holds at COMBO_MAX.
- Multiplier: 1 + count of k in 1..MULT_MAX−1 with next combo ≥ k×TIER_STEP.
  - Computed by comparisons; no divider.
- o_MaxCombo = max(o_MaxCombo, next combo).
- o_Milestone is high for one cycle when the next multiplier > the current multiplier.
  - A jump of several tiers in one cycle still gives a single pulse.
- o_FullCombo:
  - Set on the first cycle with nh > 0 and no miss.
  - Cleared by any miss.
  - Stays 0 after a miss until i_Clear.
- A cycle with no judgement inputs holds every register; o_Milestone goes to 0.

## Timing
- All outputs are registered; an input cycle t is visible at t+1.
- No handshake; inputs are single-cycle pulses sampled every clock.
- Reset asserted mid-song: outputs go to their reset values immediately. The first input sampled after deassertion is counted normally.
- Combinational path: popcount, point sum, multiply, saturate. It must close at the game clock; no pipelining is required.

## Structure
- Shared `rhythm_pkg`:
  - judgement point constants (PTS_GOOD, PTS_PERFECT defaults)
  - combo width typedef
  - MULT width constant (4)
- Sub-module `judge_sum`: combinational; LANES hits/grades/misses in, nh, pts and anyMiss out. It is reused by the judge statistics block.
- Top level holds the combo, max, multiplier, score and flag registers.

## Test plan
- Reset, then 3 single-lane good hits on separate cycles → Combo 1,2,3; Score 100,200,300; Mult 1; FullCombo 1 after the first hit.
- Drive the combo from 9 with one hit → Combo 10, Mult 2, Milestone pulses once. The next perfect hit adds 600.
- Combo 25 (Mult 3), then a cycle with 2 perfect hits plus a miss on another lane → Score +1800, Combo 0, Mult 1, MaxCombo 25, FullCombo 0.
- Same lane hit and miss in one cycle → counted as a miss; Score unchanged; Combo 0.
- Combo 998, a 4-lane hit cycle → Combo 999 and held there; Score just below 2^SCORE_W−1 → saturates, no wrap.
- i_Clear together with hits → all outputs at reset values next cycle. Async i_Rst mid-cycle → outputs 0 (Mult 1) without a clock edge.
